muldiv_issue_ctrl: RTL and testbench

// - Sequences the shared iterative M-extension unit (MUL/DIV) from the EX stage of the 5-stage pipeline.
// - Accepts an M-op once EX operands are valid, issues it to the unit and freezes PC/IF_ID/ID_EX/EX_MEM until the result returns.
// - Presents the result for one cycle so EX_MEM captures it; handles divide-by-zero bypass, flush abort and a watchdog.
// - Top level ANDs ~md_hold into pc_en, IF_ID_en and ID_EX_en; md_bubble forces a NOP into EX_MEM.

---
 rtl/muldiv_issue_ctrl_if.sv | 24 ++
 rtl/muldiv_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_issue_ctrl_if.sv
// Handshake between the EX-stage issue controller and the shared iterative MUL/DIV unit.
// The controller owns start/kill and the latched op/operands; the unit returns done and lo/hi.
interface muldiv_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            unit_start;
  logic            unit_kill;
  logic [2:0]      unit_op;
  logic [XLEN-1:0] unit_a;
  logic [XLEN-1:0] unit_b;
  logic            unit_done;
  logic [XLEN-1:0] unit_lo;
  logic [XLEN-1:0] unit_hi;

  modport master (
    output unit_start, unit_kill, unit_op, unit_a, unit_b,
    input  unit_done, unit_lo, unit_hi
  );

  modport slave (
    input  unit_start, unit_kill, unit_op, unit_a, unit_b,
    output unit_done, unit_lo, unit_hi
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage sequencer for the shared iterative M-extension unit.
// Accepts an M-op when operands are valid, issues it, holds the front of the pipe
// until the result returns, and presents the result for one cycle to EX_MEM.
// Divide-by-zero is resolved locally; flush aborts the unit; a watchdog bounds the wait.
// Optional feature: define MULDIV_RESULT_CACHE_EN to reuse the last unit result when
// a paired op ({MUL,MULH}, {DIVU,REMU}, {DIV,REM}) repeats the same operands.
module muldiv_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_md_valid,
  input  logic [2:0]             ex_md_op,
  input  logic [XLEN-1:0]        ex_rs1_data,
  input  logic [XLEN-1:0]        ex_rs2_data,
  input  logic                   hz_stall,
  input  logic                   flush,
  muldiv_issue_ctrl_if.master    unit,
  output logic                   md_hold,
  output logic                   md_bubble,
  output logic [XLEN-1:0]        md_result,
  output logic                   md_result_valid,
  output logic                   md_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Upper-half / remainder ops take unit_hi, the rest take unit_lo.
  function automatic logic pick_hi(input logic [2:0] op);
    pick_hi = op[2] ? op[1] : (op[1] | op[0]);
  endfunction

  // Divide-by-zero: quotient is all ones, remainder is the dividend.
  function automatic logic [XLEN-1:0] div_zero_result(input logic [2:0] op,
                                                       input logic [XLEN-1:0] a);
    div_zero_result = op[1] ? a : {XLEN{1'b1}};
  endfunction

  state_t            state_r;
  state_t            state_next_s;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [XLEN-1:0]   result_r;
  logic              timeout_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              accept_s;
  logic              div_zero_s;
  logic              wait_last_s;
  logic              done_take_s;
  logic              timeout_hit_s;
  logic              abort_s;
  logic              hit_s;
  logic [XLEN-1:0]   hit_lo_s;
  logic [XLEN-1:0]   hit_hi_s;

  logic              hold_s;
  logic              start_s;
  logic              kill_s;
  logic              result_valid_s;

  assign accept_s      = (state_r == ST_IDLE) & ex_md_valid & ~hz_stall & ~flush;
  assign div_zero_s    = ex_md_op[2] & (ex_rs2_data == {XLEN{1'b0}});
  assign wait_last_s   = (cnt_r == CNT_W'(TIMEOUT - 1));
  assign done_take_s   = (state_r == ST_WAIT) & ~flush & unit.unit_done;
  assign timeout_hit_s = (state_r == ST_WAIT) & ~flush & ~unit.unit_done & wait_last_s;
  assign abort_s       = ((state_r == ST_WAIT) | (state_r == ST_ISSUE)) & flush;

`ifdef MULDIV_RESULT_CACHE_EN
  // Pair code: ops sharing one unit run (same lo/hi) share a code; 2'd3 is never cached.
  function automatic logic [1:0] op_class(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: op_class = 2'd0;
      3'b101, 3'b111: op_class = 2'd1;
      3'b100, 3'b110: op_class = 2'd2;
      default:        op_class = 2'd3;
    endcase
  endfunction

  logic              c_valid_r;
  logic [XLEN-1:0]   c_a_r;
  logic [XLEN-1:0]   c_b_r;
  logic [1:0]        c_class_r;
  logic [XLEN-1:0]   c_lo_r;
  logic [XLEN-1:0]   c_hi_r;

  assign hit_s    = c_valid_r & (c_a_r == ex_rs1_data) & (c_b_r == ex_rs2_data) &
                    (c_class_r == op_class(ex_md_op)) & (op_class(ex_md_op) != 2'd3);
  assign hit_lo_s = c_lo_r;
  assign hit_hi_s = c_hi_r;

  // Result cache: filled by a returning unit result, dropped on any abort or watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_r <= 1'b0;
      c_a_r     <= {XLEN{1'b0}};
      c_b_r     <= {XLEN{1'b0}};
      c_class_r <= 2'd0;
      c_lo_r    <= {XLEN{1'b0}};
      c_hi_r    <= {XLEN{1'b0}};
    end else if (abort_s | timeout_hit_s) begin
      c_valid_r <= 1'b0;
    end else if (done_take_s & (op_class(op_r) != 2'd3)) begin
      c_valid_r <= 1'b1;
      c_a_r     <= a_r;
      c_b_r     <= b_r;
      c_class_r <= op_class(op_r);
      c_lo_r    <= unit.unit_lo;
      c_hi_r    <= unit.unit_hi;
    end
  end
`else
  assign hit_s    = 1'b0;
  assign hit_lo_s = {XLEN{1'b0}};
  assign hit_hi_s = {XLEN{1'b0}};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (div_zero_s | hit_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (unit.unit_done | wait_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Per-state outputs: pipeline hold, unit pulses and result strobe.
  always_comb begin
    hold_s         = 1'b0;
    start_s        = 1'b0;
    kill_s         = 1'b0;
    result_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        hold_s = ex_md_valid & ~flush;
      end
      ST_ISSUE: begin
        hold_s  = 1'b1;
        start_s = ~flush;
      end
      ST_WAIT: begin
        hold_s = 1'b1;
        kill_s = flush | (~unit.unit_done & wait_last_s);
      end
      ST_DONE: begin
        result_valid_s = ~flush;
      end
      default: begin
        hold_s = 1'b0;
      end
    endcase
  end

  // Operand latch and result register; operands only change on accept in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r      <= 3'b000;
      a_r       <= {XLEN{1'b0}};
      b_r       <= {XLEN{1'b0}};
      result_r  <= {XLEN{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if (accept_s) begin
        op_r <= ex_md_op;
        a_r  <= ex_rs1_data;
        b_r  <= ex_rs2_data;
      end
      if (accept_s & div_zero_s) begin
        result_r <= div_zero_result(ex_md_op, ex_rs1_data);
      end else if (accept_s & hit_s) begin
        result_r <= pick_hi(ex_md_op) ? hit_hi_s : hit_lo_s;
      end else if (done_take_s) begin
        result_r <= pick_hi(op_r) ? unit.unit_hi : unit.unit_lo;
      end else if (timeout_hit_s) begin
        result_r <= {XLEN{1'b0}};
      end
      if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  // Watchdog counter: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign unit.unit_start = start_s;
  assign unit.unit_kill  = kill_s;
  assign unit.unit_op    = op_r;
  assign unit.unit_a     = a_r;
  assign unit.unit_b     = b_r;

  assign md_hold         = hold_s;
  assign md_bubble       = hold_s;
  assign md_result       = result_r;
  assign md_result_valid = result_valid_s;
  assign md_timeout      = timeout_r;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: directed scenarios with literal expectations, then
// randomized traffic against a transaction-level model and an emulated MUL/DIV unit.
module tb_muldiv_issue_ctrl;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_md_valid;
  logic [2:0]  ex_md_op;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic        hz_stall;
  logic        flush;
  logic        md_hold;
  logic        md_bubble;
  logic [31:0] md_result;
  logic        md_result_valid;
  logic        md_timeout;

  muldiv_issue_ctrl_if #(.XLEN(XLEN)) ubus ();

  muldiv_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_md_valid     (ex_md_valid),
    .ex_md_op        (ex_md_op),
    .ex_rs1_data     (ex_rs1_data),
    .ex_rs2_data     (ex_rs2_data),
    .hz_stall        (hz_stall),
    .flush           (flush),
    .unit            (ubus),
    .md_hold         (md_hold),
    .md_bubble       (md_bubble),
    .md_result       (md_result),
    .md_result_valid (md_result_valid),
    .md_timeout      (md_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // sampled DUT outputs of the current cycle
  logic        s_hold, s_bubble, s_start, s_kill, s_rv, s_to;
  logic [31:0] s_res, s_ua, s_ub;
  logic [2:0]  s_uop;

  // transaction-level model
  bit          m_issue, m_wait, m_done, m_to;
  int          m_cnt;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  bit          mc_valid;
  logic [31:0] mc_a, mc_b;
  int          mc_cls;

  // emulated unit
  bit          u_busy, late_pend, force_late, rand_mode;
  int          u_rem, next_lat;
  logic [2:0]  u_op;
  logic [31:0] u_a, u_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension result of one op.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, sp;
    logic [63:0] up;
    logic signed [31:0] qa, qb;
    qa = a;
    qb = b;
    sa = longint'(qa);
    sb = longint'(qb);
    case (op)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'd1: begin sp = sa * sb; up = sp; return up[63:32]; end
      3'd2: begin sp = sa * longint'({32'd0, b}); up = sp; return up[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return qa / qb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return qa % qb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int cls_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 0;
      3'd5, 3'd7: return 1;
      3'd4, 3'd6: return 2;
      default:    return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_issue = 0; m_wait = 0; m_done = 0; m_to = 0; m_cnt = 0;
    m_op = 3'd0; m_a = 32'd0; m_b = 32'd0; m_res = 32'd0;
    mc_valid = 0; mc_a = 32'd0; mc_b = 32'd0; mc_cls = 0;
  endtask

  // One clock cycle: drive inputs, emulate the unit, compare, advance model.
  task automatic step(input bit r, input bit v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit st, input bit fl);
    bit idle, e_hold, e_start, e_kill, e_rv, dn, hit;
    logic [31:0] lo, hi;
    @(negedge clk);
    rst = r; ex_md_valid = v; ex_md_op = op; ex_rs1_data = a; ex_rs2_data = b;
    hz_stall = st; flush = fl;
    dn = 0; lo = $urandom; hi = $urandom;
    if (late_pend) begin
      dn = 1; late_pend = 0;
    end else if (u_busy) begin
      u_rem--;
      if (u_rem == 0) begin
        dn = 1; u_busy = 0;
        if (!u_op[2]) begin
          lo = ref_op(3'd0, u_a, u_b);
          hi = ref_op((u_op == 3'd0) ? 3'd1 : u_op, u_a, u_b);
        end else if (!u_op[0]) begin
          lo = ref_op(3'd4, u_a, u_b); hi = ref_op(3'd6, u_a, u_b);
        end else begin
          lo = ref_op(3'd5, u_a, u_b); hi = ref_op(3'd7, u_a, u_b);
        end
      end
    end
    ubus.unit_done = dn; ubus.unit_lo = lo; ubus.unit_hi = hi;
    #1;
    s_hold = md_hold; s_bubble = md_bubble; s_start = ubus.unit_start; s_kill = ubus.unit_kill;
    s_rv = md_result_valid; s_res = md_result; s_to = md_timeout;
    s_uop = ubus.unit_op; s_ua = ubus.unit_a; s_ub = ubus.unit_b;
    if (!r) begin
      idle    = !m_issue && !m_wait && !m_done;
      e_hold  = (idle && v && !fl) || m_issue || m_wait;
      e_start = m_issue && !fl;
      e_kill  = m_wait && (fl || (!dn && m_cnt == TIMEOUT - 1));
      e_rv    = m_done && !fl;
      chk("md_hold", s_hold, e_hold);
      chk("md_bubble", s_bubble, e_hold);
      chk("unit_start", s_start, e_start);
      chk("unit_kill", s_kill, e_kill);
      chk("md_result_valid", s_rv, e_rv);
      chk("md_result", s_res, m_res);
      chk("md_timeout", s_to, m_to);
      if (m_issue || m_wait) begin
        chk("unit_op", s_uop, m_op);
        chk("unit_a", s_ua, m_a);
        chk("unit_b", s_ub, m_b);
      end
    end
    // emulated unit reacts to this cycle's pulses
    if (r) begin
      u_busy = 0; late_pend = 0;
    end else begin
      if (s_kill) begin
        u_busy = 0;
        late_pend = force_late || (rand_mode && ($urandom_range(1, 0) == 1));
      end
      if (s_start) begin
        u_busy = 1;
        u_rem  = rand_mode ? (($urandom_range(39, 0) == 0) ? 1000 : $urandom_range(6, 1))
                           : next_lat;
        u_op = s_uop; u_a = s_ua; u_b = s_ub;
      end
    end
    // model advance
    if (r) begin
      model_reset();
    end else if (m_issue) begin
      m_issue = 0;
      if (fl) begin
        mc_valid = 0;
      end else begin
        m_wait = 1; m_cnt = 0;
      end
    end else if (m_wait) begin
      if (fl) begin
        m_wait = 0; mc_valid = 0;
      end else if (dn) begin
        m_wait = 0; m_done = 1; m_res = ref_op(m_op, m_a, m_b);
        if (cls_of(m_op) >= 0) begin
          mc_valid = 1; mc_a = m_a; mc_b = m_b; mc_cls = cls_of(m_op);
        end
      end else if (m_cnt == TIMEOUT - 1) begin
        m_wait = 0; m_done = 1; m_res = 32'd0; m_to = 1; mc_valid = 0;
      end else begin
        m_cnt++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (v && !st && !fl) begin
      m_op = op; m_a = a; m_b = b;
`ifdef MULDIV_RESULT_CACHE_EN
      hit = mc_valid && mc_a == a && mc_b == b && cls_of(op) >= 0 && mc_cls == cls_of(op);
`else
      hit = 0;
`endif
      if ((op[2] && b == 32'd0) || hit) begin
        m_done = 1; m_res = ref_op(op, a, b);
      end else begin
        m_issue = 1;
      end
    end
  endtask

  function automatic logic [31:0] pick_a();
    case ($urandom_range(5, 0))
      0: return 32'd100;
      1: return 32'd7;
      2: return 32'd0;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    case ($urandom_range(5, 0))
      0: return 32'd7;
      1: return 32'd0;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'd100;
      default: return $urandom;
    endcase
  endfunction

  int h, stc, rvc, rv_at, kc, kill_at, st_at;
  logic [31:0] rres;

  task automatic clr_tally();
    h = 0; stc = 0; rvc = 0; rv_at = -1; kc = 0; kill_at = -1; st_at = -1; rres = 32'd0;
  endtask

  task automatic tally(input int i);
    h += int'(s_hold);
    if (s_start) begin stc++; st_at = i; end
    if (s_kill) begin kc++; kill_at = i; end
    if (s_rv) begin rvc++; rv_at = i; rres = s_res; end
  endtask

  initial begin
    rst = 1'b1; ex_md_valid = 1'b0; ex_md_op = 3'd0; ex_rs1_data = 32'd0; ex_rs2_data = 32'd0;
    hz_stall = 1'b0; flush = 1'b0;
    ubus.unit_done = 1'b0; ubus.unit_lo = 32'd0; ubus.unit_hi = 32'd0;
    u_busy = 0; late_pend = 0; force_late = 0; rand_mode = 0; u_rem = 0; next_lat = 3;
    u_op = 3'd0; u_a = 32'd0; u_b = 32'd0;
    model_reset();

    // reset state
    step(1, 0, 3'd0, 32'd0, 32'd0, 0, 0);
    step(1, 0, 3'd0, 32'd0, 32'd0, 0, 0);
    step(0, 0, 3'd0, 32'd0, 32'd0, 0, 0);
    chk("rst_hold", s_hold, 1'b0);
    chk("rst_result", s_res, 32'd0);
    chk("rst_timeout", s_to, 1'b0);
    chk("rst_unit_a", s_ua, 32'd0);

    // DIV 100/7, unit answers 3 cycles after start
    clr_tally(); next_lat = 3;
    for (int i = 0; i < 8; i++) begin
      step(0, i < 6, 3'd4, 32'd100, 32'd7, 0, 0); tally(i);
    end
    chk("div_hold_cycles", h, 5);
    chk("div_starts", stc, 1);
    chk("div_valid_count", rvc, 1);
    chk("div_valid_cycle", rv_at, 5);
    chk("div_result", rres, 32'd14);

    // DIVU 5/0 bypass
    clr_tally();
    for (int i = 0; i < 4; i++) begin
      step(0, i < 2, 3'd5, 32'd5, 32'd0, 0, 0); tally(i);
    end
    chk("divu0_starts", stc, 0);
    chk("divu0_valid_cycle", rv_at, 1);
    chk("divu0_result", rres, 32'hFFFF_FFFF);

    // REM 5/0 bypass
    clr_tally();
    for (int i = 0; i < 4; i++) begin
      step(0, i < 2, 3'd6, 32'd5, 32'd0, 0, 0); tally(i);
    end
    chk("rem0_starts", stc, 0);
    chk("rem0_result", rres, 32'd5);

    // load-use stall for two cycles, then MUL 6*7
    clr_tally(); next_lat = 2;
    for (int i = 0; i < 9; i++) begin
      step(0, i < 7, 3'd0, 32'd6, 32'd7, i < 2, 0); tally(i);
      if (i < 2) chk("stall_hold", s_hold, 1'b1);
    end
    chk("stall_start_cycle", st_at, 3);
    chk("stall_starts", stc, 1);
    chk("mul_result", rres, 32'd42);

    // flush during WAIT, then a stray late done
    clr_tally(); next_lat = 10; force_late = 1;
    for (int i = 0; i < 9; i++) begin
      step(0, i < 4, 3'd4, 32'd100, 32'd7, 0, i == 3); tally(i);
      if (i == 4) chk("flush_idle_hold", s_hold, 1'b0);
    end
    force_late = 0;
    chk("flush_kill_cycle", kill_at, 3);
    chk("flush_kills", kc, 1);
    chk("flush_valid_count", rvc, 0);

    // watchdog: unit never answers
    clr_tally(); next_lat = 100000;
    for (int i = 0; i < 70; i++) begin
      step(0, i < 67, 3'd3, 32'd5, 32'd9, 0, 0); tally(i);
    end
    chk("wd_kill_cycle", kill_at, 65);
    chk("wd_valid_cycle", rv_at, 66);
    chk("wd_valid_count", rvc, 1);
    chk("wd_result", rres, 32'd0);
    chk("wd_timeout_flag", s_to, 1'b1);

`ifdef MULDIV_RESULT_CACHE_EN
    // DIV 100/7 through the unit, REM 100/7 from the cache
    clr_tally(); next_lat = 3;
    for (int i = 0; i < 8; i++) begin
      step(0, i < 6, 3'd4, 32'd100, 32'd7, 0, 0); tally(i);
    end
    clr_tally();
    for (int i = 0; i < 4; i++) begin
      step(0, i < 2, 3'd6, 32'd100, 32'd7, 0, 0); tally(i);
    end
    chk("cache_starts", stc, 0);
    chk("cache_valid_cycle", rv_at, 1);
    chk("cache_result", rres, 32'd2);
`endif

    // reset clears the sticky watchdog flag
    step(1, 0, 3'd0, 32'd0, 32'd0, 0, 0);
    step(0, 0, 3'd0, 32'd0, 32'd0, 0, 0);
    chk("rst_clears_timeout", s_to, 1'b0);
    chk("rst_clears_result", s_res, 32'd0);

    // randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(499, 0) == 0, $urandom_range(3, 0) != 0, 3'($urandom_range(7, 0)),
           pick_a(), pick_b(), $urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0);
    end
    rand_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
